// File: rtl/act_arb_pkg.sv
// Shared types and constants for the activation-memory write arbiter.
// Holds the arbiter state encoding, the default drain burst length and counter widths.
package act_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXT   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam int NB_DRAIN_WORDS_DEF = 16;
  localparam int XFER_CNT_W         = 4;
  localparam int STALL_CNT_W        = 16;

endpackage

// File: rtl/act_mem_write_arbiter.sv
// Arbitrates the single activation-memory write port between the external load stream and PE-array drains.
// Optional macro ACT_ARB_STALL_CNT_EN adds a saturating counter of stalled external-stream cycles.
module act_mem_write_arbiter
  import act_arb_pkg::*;
#(
  parameter int MEM_BW         = 128,
  parameter int ADDR_WIDTH_ACT = 14,
  parameter int NB_DRAIN_WORDS = NB_DRAIN_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      ext_valid,
  output logic                      ext_ready,
  input  logic [ADDR_WIDTH_ACT-1:0] ext_addr,
  input  logic [MEM_BW-1:0]         ext_data,
  input  logic                      drain_req,
  input  logic [ADDR_WIDTH_ACT-1:0] drain_base_addr,
  input  logic [MEM_BW-1:0]         packed_data,
  output logic [3:0]                mem_transfer_counter,
  output logic                      outputs_to_memory_flag,
  output logic                      mem_csb,
  output logic [ADDR_WIDTH_ACT-1:0] mem_addr,
  output logic [MEM_BW-1:0]         mem_din,
  output logic                      drain_done,
  output logic                      busy,
  output logic [15:0]               stall_cnt
);

  localparam logic [XFER_CNT_W-1:0] CNT_LAST = XFER_CNT_W'(NB_DRAIN_WORDS - 1);

  arb_state_e                state_q, state_d;
  logic                      pending_q;
  logic [ADDR_WIDTH_ACT-1:0] pend_base_q;
  logic [ADDR_WIDTH_ACT-1:0] act_base_q;
  logic [XFER_CNT_W-1:0]     cnt_q;
  logic                      run_q;
  logic                      done_p1;
  logic [ADDR_WIDTH_ACT-1:0] addr_p1;
  logic [MEM_BW-1:0]         din_p1;

  logic drain_any;
  logic in_drain;
  logic last_word;
  logic ext_wr;
  logic burst_start;

  // A request arriving this cycle counts as pending so the drain starts on the very next cycle.
  assign drain_any   = pending_q | drain_req;
  assign in_drain    = (state_q == ST_DRAIN);
  assign last_word   = in_drain && (cnt_q == CNT_LAST);
  assign ext_ready   = run_q && !in_drain && !drain_any;
  assign ext_wr      = ext_valid && ext_ready;
  assign burst_start = (state_d == ST_DRAIN) && (!in_drain || last_word);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_EXT: begin
        if (drain_any)   state_d = ST_DRAIN;
        else if (ext_wr) state_d = ST_EXT;
        else             state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (last_word) state_d = drain_any ? ST_DRAIN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_csb                = 1'b1;
    mem_addr               = addr_p1;
    mem_din                = din_p1;
    outputs_to_memory_flag = 1'b0;
    if (in_drain) begin
      mem_csb                = 1'b0;
      mem_addr               = act_base_q + ADDR_WIDTH_ACT'(cnt_q);
      mem_din                = packed_data;
      outputs_to_memory_flag = 1'b1;
    end else if (ext_wr) begin
      mem_csb  = 1'b0;
      mem_addr = ext_addr;
      mem_din  = ext_data;
    end
  end

  // Only one pending slot: a later request overwrites the latched base.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      pending_q   <= 1'b0;
      pend_base_q <= '0;
      act_base_q  <= '0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (burst_start)    pending_q <= 1'b0;
      else if (drain_req) pending_q <= 1'b1;
      if (drain_req) pend_base_q <= drain_base_addr;
      if (burst_start) act_base_q <= drain_req ? drain_base_addr : pend_base_q;
      if (in_drain && !last_word) cnt_q <= cnt_q + 1'b1;
      else                        cnt_q <= '0;
    end
  end

  // Stage p1: completion pulse and hold registers for the write port.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      done_p1 <= 1'b0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      done_p1 <= last_word;
      addr_p1 <= mem_addr;
      din_p1  <= mem_din;
    end
  end

  assign mem_transfer_counter = cnt_q;
  assign drain_done           = done_p1;
  assign busy                 = (state_q != ST_IDLE) || pending_q;

`ifdef ACT_ARB_STALL_CNT_EN
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)                   stall_q <= '0;
    else if (ext_valid && !ext_ready) stall_q <= sat_inc(stall_q);
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_act_mem_write_arbiter.sv
// Self-checking bench for act_mem_write_arbiter: directed scenarios plus a randomized run
// compared against a queue-based model of scheduled drain writes.
module tb_act_mem_write_arbiter;

  logic         clk;
  logic         arst_n_in;
  logic         ext_valid;
  logic         ext_ready;
  logic [13:0]  ext_addr;
  logic [127:0] ext_data;
  logic         drain_req;
  logic [13:0]  drain_base_addr;
  logic [127:0] packed_data;
  logic [3:0]   mem_transfer_counter;
  logic         outputs_to_memory_flag;
  logic         mem_csb;
  logic [13:0]  mem_addr;
  logic [127:0] mem_din;
  logic         drain_done;
  logic         busy;
  logic [15:0]  stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  act_mem_write_arbiter dut (
    .clk                   (clk),
    .arst_n_in             (arst_n_in),
    .ext_valid             (ext_valid),
    .ext_ready             (ext_ready),
    .ext_addr              (ext_addr),
    .ext_data              (ext_data),
    .drain_req             (drain_req),
    .drain_base_addr       (drain_base_addr),
    .packed_data           (packed_data),
    .mem_transfer_counter  (mem_transfer_counter),
    .outputs_to_memory_flag(outputs_to_memory_flag),
    .mem_csb               (mem_csb),
    .mem_addr              (mem_addr),
    .mem_din               (mem_din),
    .drain_done            (drain_done),
    .busy                  (busy),
    .stall_cnt             (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    #2;
    n_checks++; if (mem_csb !== 1'b1) $display("FAIL rst_csb got %0h want 1", mem_csb); else n_pass++;
    n_checks++; if (mem_addr !== 14'h0) $display("FAIL rst_addr got %0h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== 128'h0) $display("FAIL rst_din got %0h want 0", mem_din); else n_pass++;
    n_checks++; if (ext_ready !== 1'b0) $display("FAIL rst_ready got %0h want 0", ext_ready); else n_pass++;
    n_checks++; if (drain_done !== 1'b0) $display("FAIL rst_done got %0h want 0", drain_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0h want 0", busy); else n_pass++;
    n_checks++; if (outputs_to_memory_flag !== 1'b0) $display("FAIL rst_flag got %0h want 0", outputs_to_memory_flag); else n_pass++;
    n_checks++; if (mem_transfer_counter !== 4'h0) $display("FAIL rst_cnt got %0h want 0", mem_transfer_counter); else n_pass++;
    n_checks++; if (stall_cnt !== 16'h0) $display("FAIL rst_stall got %0h want 0", stall_cnt); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    #2;
    n_checks++; if (ext_ready !== 1'b1) $display("FAIL rel_ready got %0h want 1", ext_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ext_stream();
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d         = rnd128();
      ext_valid = 1'b1;
      ext_addr  = 14'h0010 + 14'(i);
      ext_data  = d;
      #2;
      n_checks++; if (mem_csb !== 1'b0) $display("FAIL ext_csb[%0d] got %0h want 0", i, mem_csb); else n_pass++;
      n_checks++; if (mem_addr !== 14'h0010 + 14'(i)) $display("FAIL ext_addr[%0d] got %0h want %0h", i, mem_addr, 14'h0010 + 14'(i)); else n_pass++;
      n_checks++; if (mem_din !== d) $display("FAIL ext_din[%0d] got %0h want %0h", i, mem_din, d); else n_pass++;
      n_checks++; if (ext_ready !== 1'b1) $display("FAIL ext_ready[%0d] got %0h want 1", i, ext_ready); else n_pass++;
      n_checks++; if (outputs_to_memory_flag !== 1'b0) $display("FAIL ext_flag[%0d] got %0h want 0", i, outputs_to_memory_flag); else n_pass++;
      @(negedge clk);
    end
    ext_valid = 1'b0;
    ext_data  = rnd128();
    #2;
    n_checks++; if (mem_csb !== 1'b1) $display("FAIL ext_idle_csb got %0h want 1", mem_csb); else n_pass++;
    n_checks++; if (mem_addr !== 14'h0013) $display("FAIL ext_hold_addr got %0h want 13", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== d) $display("FAIL ext_hold_din got %0h want %0h", mem_din, d); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_drain();
    logic [127:0] p;
    drain_req       = 1'b1;
    drain_base_addr = 14'h0100;
    #2;
    n_checks++; if (ext_ready !== 1'b0) $display("FAIL drn_req_ready got %0h want 0", ext_ready); else n_pass++;
    @(negedge clk);
    drain_req       = 1'b0;
    drain_base_addr = 14'h2AAA;
    for (int i = 0; i < 16; i++) begin
      p           = rnd128();
      packed_data = p;
      #2;
      n_checks++; if (mem_csb !== 1'b0) $display("FAIL drn_csb[%0d] got %0h want 0", i, mem_csb); else n_pass++;
      n_checks++; if (mem_addr !== 14'h0100 + 14'(i)) $display("FAIL drn_addr[%0d] got %0h want %0h", i, mem_addr, 14'h0100 + 14'(i)); else n_pass++;
      n_checks++; if (mem_din !== p) $display("FAIL drn_din[%0d] got %0h want %0h", i, mem_din, p); else n_pass++;
      n_checks++; if (mem_transfer_counter !== 4'(i)) $display("FAIL drn_cnt[%0d] got %0h want %0h", i, mem_transfer_counter, 4'(i)); else n_pass++;
      n_checks++; if (outputs_to_memory_flag !== 1'b1) $display("FAIL drn_flag[%0d] got %0h want 1", i, outputs_to_memory_flag); else n_pass++;
      n_checks++; if (drain_done !== 1'b0) $display("FAIL drn_early_done[%0d] got %0h want 0", i, drain_done); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL drn_busy[%0d] got %0h want 1", i, busy); else n_pass++;
      @(negedge clk);
    end
    #2;
    n_checks++; if (drain_done !== 1'b1) $display("FAIL drn_done got %0h want 1", drain_done); else n_pass++;
    n_checks++; if (mem_csb !== 1'b1) $display("FAIL drn_end_csb got %0h want 1", mem_csb); else n_pass++;
    n_checks++; if (mem_transfer_counter !== 4'h0) $display("FAIL drn_end_cnt got %0h want 0", mem_transfer_counter); else n_pass++;
    n_checks++; if (mem_addr !== 14'h010F) $display("FAIL drn_end_addr got %0h want 10f", mem_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL drn_end_busy got %0h want 0", busy); else n_pass++;
    @(negedge clk);
    #2;
    n_checks++; if (drain_done !== 1'b0) $display("FAIL drn_done_len got %0h want 0", drain_done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ext_during_drain();
    logic [127:0] d;
    logic [13:0]  a;
    int           low_cnt;
    logic [15:0]  stall_exp;
`ifdef ACT_ARB_STALL_CNT_EN
    stall_exp = 16'd17;
`else
    stall_exp = 16'd0;
`endif
    low_cnt         = 0;
    d               = rnd128();
    ext_valid       = 1'b1;
    ext_addr        = 14'h0055;
    ext_data        = d;
    drain_req       = 1'b1;
    drain_base_addr = 14'h3FF8;
    #2;
    if (ext_ready === 1'b0) low_cnt++;
    n_checks++; if (mem_csb !== 1'b1) $display("FAIL wrap_req_csb got %0h want 1", mem_csb); else n_pass++;
    @(negedge clk);
    drain_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      packed_data = rnd128();
      a           = 14'h3FF8 + 14'(i);
      #2;
      if (ext_ready === 1'b0) low_cnt++;
      n_checks++; if (mem_addr !== a) $display("FAIL wrap_addr[%0d] got %0h want %0h", i, mem_addr, a); else n_pass++;
      n_checks++; if (outputs_to_memory_flag !== 1'b1) $display("FAIL wrap_flag[%0d] got %0h want 1", i, outputs_to_memory_flag); else n_pass++;
      @(negedge clk);
    end
    #2;
    n_checks++; if (low_cnt != 17) $display("FAIL wrap_ready_low got %0d want 17", low_cnt); else n_pass++;
    n_checks++; if (ext_ready !== 1'b1) $display("FAIL wrap_ready_back got %0h want 1", ext_ready); else n_pass++;
    n_checks++; if (drain_done !== 1'b1) $display("FAIL wrap_done got %0h want 1", drain_done); else n_pass++;
    n_checks++; if (mem_csb !== 1'b0) $display("FAIL wrap_ext_csb got %0h want 0", mem_csb); else n_pass++;
    n_checks++; if (mem_addr !== 14'h0055) $display("FAIL wrap_ext_addr got %0h want 55", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== d) $display("FAIL wrap_ext_din got %0h want %0h", mem_din, d); else n_pass++;
    @(negedge clk);
    ext_valid = 1'b0;
    #2;
    n_checks++; if (stall_cnt !== stall_exp) $display("FAIL wrap_stall got %0d want %0d", stall_cnt, stall_exp); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [13:0] a;
    drain_req       = 1'b1;
    drain_base_addr = 14'h0300;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      drain_req       = (i == 3) || (i == 5);
      drain_base_addr = (i == 3) ? 14'h0777 : 14'h0200;
      packed_data     = rnd128();
      a               = (i < 16) ? 14'h0300 + 14'(i) : 14'h0200 + 14'(i - 16);
      #2;
      n_checks++; if (mem_csb !== 1'b0) $display("FAIL b2b_csb[%0d] got %0h want 0", i, mem_csb); else n_pass++;
      n_checks++; if (mem_addr !== a) $display("FAIL b2b_addr[%0d] got %0h want %0h", i, mem_addr, a); else n_pass++;
      n_checks++; if (mem_transfer_counter !== 4'(i % 16)) $display("FAIL b2b_cnt[%0d] got %0h want %0h", i, mem_transfer_counter, 4'(i % 16)); else n_pass++;
      n_checks++; if (drain_done !== (i == 16)) $display("FAIL b2b_done[%0d] got %0h want %0h", i, drain_done, (i == 16)); else n_pass++;
      @(negedge clk);
    end
    drain_req = 1'b0;
    #2;
    n_checks++; if (drain_done !== 1'b1) $display("FAIL b2b_done2 got %0h want 1", drain_done); else n_pass++;
    n_checks++; if (mem_csb !== 1'b1) $display("FAIL b2b_end_csb got %0h want 1", mem_csb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_end_busy got %0h want 0", busy); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    drain_req       = 1'b1;
    drain_base_addr = 14'h0400;
    @(negedge clk);
    drain_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      n_checks++; if (mem_transfer_counter !== 4'(i)) $display("FAIL rmd_cnt[%0d] got %0h want %0h", i, mem_transfer_counter, 4'(i)); else n_pass++;
      if (i < 7) @(negedge clk);
    end
    #1;
    arst_n_in = 1'b0;
    #1;
    n_checks++; if (mem_csb !== 1'b1) $display("FAIL rmd_csb got %0h want 1", mem_csb); else n_pass++;
    n_checks++; if (mem_transfer_counter !== 4'h0) $display("FAIL rmd_cnt0 got %0h want 0", mem_transfer_counter); else n_pass++;
    n_checks++; if (outputs_to_memory_flag !== 1'b0) $display("FAIL rmd_flag got %0h want 0", outputs_to_memory_flag); else n_pass++;
    n_checks++; if (ext_ready !== 1'b0) $display("FAIL rmd_ready got %0h want 0", ext_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmd_busy got %0h want 0", busy); else n_pass++;
    n_checks++; if (mem_addr !== 14'h0) $display("FAIL rmd_addr got %0h want 0", mem_addr); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_checks++; if (drain_done !== 1'b0) $display("FAIL rmd_done got %0h want 0", drain_done); else n_pass++;
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    #2;
    n_checks++; if (ext_ready !== 1'b1) $display("FAIL rmd_rel_ready got %0h want 1", ext_ready); else n_pass++;
    n_checks++; if (drain_done !== 1'b0) $display("FAIL rmd_rel_done got %0h want 0", drain_done); else n_pass++;
    @(negedge clk);
    drain_req       = 1'b1;
    drain_base_addr = 14'h0500;
    @(negedge clk);
    drain_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #2;
      n_checks++; if (mem_transfer_counter !== 4'(i)) $display("FAIL rmd_re_cnt[%0d] got %0h want %0h", i, mem_transfer_counter, 4'(i)); else n_pass++;
      n_checks++; if (mem_addr !== 14'h0500 + 14'(i)) $display("FAIL rmd_re_addr[%0d] got %0h want %0h", i, mem_addr, 14'h0500 + 14'(i)); else n_pass++;
      @(negedge clk);
    end
    #2;
    n_checks++; if (drain_done !== 1'b1) $display("FAIL rmd_re_done got %0h want 1", drain_done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [13:0]  e_addr, l_addr, pbase, pb;
    logic [127:0] e_din, l_din;
    logic         e_csb, e_flag, e_rdy, e_done, d_next, pend;
    logic [3:0]   e_cnt;
    int           stalls;
    int           sa[$];
    int           si[$];
    logic [15:0]  stall_exp;
    ext_valid = 1'b0;
    drain_req = 1'b0;
    arst_n_in = 1'b0;
    @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    l_addr = '0; l_din = '0; d_next = 1'b0; pend = 1'b0; pbase = '0; stalls = 0;
    for (int c = 0; c < 400; c++) begin
      drain_req       = ($urandom_range(0, 24) == 0);
      drain_base_addr = 14'($urandom);
      ext_valid       = 1'($urandom);
      ext_addr        = 14'($urandom);
      ext_data        = rnd128();
      packed_data     = rnd128();
      #2;
      e_rdy  = (sa.size() == 0) && !pend && !drain_req;
      e_done = d_next;
      if (sa.size() != 0) begin
        e_csb = 1'b0; e_addr = 14'(sa[0]); e_din = packed_data; e_flag = 1'b1; e_cnt = 4'(si[0]);
      end else if (ext_valid && e_rdy) begin
        e_csb = 1'b0; e_addr = ext_addr; e_din = ext_data; e_flag = 1'b0; e_cnt = 4'h0;
      end else begin
        e_csb = 1'b1; e_addr = l_addr; e_din = l_din; e_flag = 1'b0; e_cnt = 4'h0;
      end
      n_checks++; if (ext_ready !== e_rdy) $display("FAIL rnd_ready[%0d] got %0h want %0h", c, ext_ready, e_rdy); else n_pass++;
      n_checks++; if (mem_csb !== e_csb) $display("FAIL rnd_csb[%0d] got %0h want %0h", c, mem_csb, e_csb); else n_pass++;
      n_checks++; if (mem_addr !== e_addr) $display("FAIL rnd_addr[%0d] got %0h want %0h", c, mem_addr, e_addr); else n_pass++;
      n_checks++; if (mem_din !== e_din) $display("FAIL rnd_din[%0d] got %0h want %0h", c, mem_din, e_din); else n_pass++;
      n_checks++; if (outputs_to_memory_flag !== e_flag) $display("FAIL rnd_flag[%0d] got %0h want %0h", c, outputs_to_memory_flag, e_flag); else n_pass++;
      n_checks++; if (mem_transfer_counter !== e_cnt) $display("FAIL rnd_cnt[%0d] got %0h want %0h", c, mem_transfer_counter, e_cnt); else n_pass++;
      n_checks++; if (drain_done !== e_done) $display("FAIL rnd_done[%0d] got %0h want %0h", c, drain_done, e_done); else n_pass++;
      if (ext_valid && !e_rdy) stalls++;
      l_addr = e_addr;
      l_din  = e_din;
      d_next = (sa.size() != 0) && (si[0] == 15);
      if (sa.size() != 0) begin
        void'(sa.pop_front());
        void'(si.pop_front());
      end
      if ((sa.size() == 0) && (drain_req || pend)) begin
        pb = drain_req ? drain_base_addr : pbase;
        for (int k = 0; k < 16; k++) begin
          sa.push_back((int'(pb) + k) % 16384);
          si.push_back(k);
        end
        pend = 1'b0;
      end else if (drain_req) begin
        pend  = 1'b1;
        pbase = drain_base_addr;
      end
      @(negedge clk);
    end
    drain_req = 1'b0;
    ext_valid = 1'b0;
`ifdef ACT_ARB_STALL_CNT_EN
    stall_exp = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
`else
    stall_exp = 16'h0;
`endif
    #2;
    n_checks++; if (stall_cnt !== stall_exp) $display("FAIL rnd_stall got %0d want %0d", stall_cnt, stall_exp); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    arst_n_in       = 1'b0;
    ext_valid       = 1'b0;
    ext_addr        = '0;
    ext_data        = '0;
    drain_req       = 1'b0;
    drain_base_addr = '0;
    packed_data     = '0;
    test_reset();
    test_ext_stream();
    test_drain();
    test_ext_during_drain();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/act_mem_write_arbiter.md
ACT_MEM_WRITE_ARBITER -- requirements
Module: act_mem_write_arbiter

Interface
REQ-001 Parameters SHALL be: MEM_BW, 128, write data width; ADDR_WIDTH_ACT, 14, activation memory address width; NB_DRAIN_WORDS, 16, writes per drain burst.
REQ-002 Ports SHALL be: clk in 1 clock; arst_n_in in 1 reset. One clock; reset is asynchronous and active-low.
REQ-003 ext_valid in 1, ext_ready out 1, ext_addr in ADDR_WIDTH_ACT, ext_data in MEM_BW: external activation load stream.
REQ-004 drain_req in 1: single-cycle pulse, PE array results ready; drain_base_addr in ADDR_WIDTH_ACT: first drain address, sampled with drain_req.
REQ-005 packed_data in MEM_BW: packer output for the current transfer index.
REQ-006 mem_transfer_counter out 4: drain word index; outputs_to_memory_flag out 1: drain owns the port.
REQ-007 mem_csb out 1: active-low write select; mem_addr out ADDR_WIDTH_ACT; mem_din out MEM_BW.
REQ-008 drain_done out 1: one-cycle pulse after the last drain write; busy out 1: state != IDLE or drain pending.
REQ-009 stall_cnt out 16: external-stall count (see Configuration).

Function
REQ-010 FSM states SHALL be IDLE, EXT, DRAIN; EXT = cycle with an accepted external write.
REQ-011 A drain_req pulse SHALL set a pending flag and latch drain_base_addr; pending clears when DRAIN is entered.
REQ-012 Drain SHALL have strict priority: ext_ready = 0 whenever pending is set or state is DRAIN; ext_ready SHALL NOT depend on ext_valid.
REQ-013 From IDLE/EXT with pending set, next state SHALL be DRAIN; otherwise EXT if ext_valid&&ext_ready, else IDLE.
REQ-014 External write: in the ext_valid&&ext_ready cycle, mem_csb = 0, mem_addr = ext_addr, mem_din = ext_data, outputs_to_memory_flag = 0 (zero latency).
REQ-015 In DRAIN, every cycle SHALL write: mem_csb = 0, mem_addr = base + counter modulo 2^ADDR_WIDTH_ACT, mem_din = packed_data, outputs_to_memory_flag = 1.
REQ-016 Counter SHALL run 0..NB_DRAIN_WORDS-1, one step per cycle, no stall; DRAIN lasts exactly NB_DRAIN_WORDS cycles.
REQ-017 drain_done SHALL pulse in the cycle after the write with counter = NB_DRAIN_WORDS-1; counter returns to 0.
REQ-018 A drain_req during DRAIN SHALL set pending; the next burst SHALL start the cycle after the last write, with no IDLE gap; drain_done still pulses.
REQ-019 drain_req while pending already set SHALL overwrite the latched base (one pending slot).
REQ-020 Simultaneous ext_valid and drain_req in IDLE: external not accepted (ready already 0 next cycle); drain starts next cycle.
REQ-021 Outside writes mem_csb = 1, mem_addr and mem_din SHALL hold their last values.

Reset
REQ-022 Asserting arst_n_in SHALL immediately force: state IDLE, pending 0, counter 0, mem_csb 1, mem_addr 0, mem_din 0, ext_ready 0, drain_done 0, busy 0, outputs_to_memory_flag 0, stall_cnt 0.
REQ-023 Reset mid-drain SHALL abort the burst with no drain_done; ext_ready rises the first cycle after release.

Configuration
REQ-024 Macro ACT_ARB_STALL_CNT_EN: when defined, stall_cnt increments each cycle ext_valid=1 && ext_ready=0, saturating at 16'hFFFF; when undefined, stall_cnt is tied to 0 and no counter flops exist.

Structure
REQ-025 Package act_arb_pkg SHALL hold the state enum, NB_DRAIN_WORDS default and the stall-counter width.
REQ-026 No sub-module; state, pending, base and counters use the codebase's register cell.

Verification
REQ-027 Ext stream 4 words, addr 0x0010..0x0013, no drain -> 4 consecutive writes, csb=0, ext_ready stays 1.
REQ-028 drain_req with base 0x0100 in IDLE -> 16 writes at 0x0100..0x010F, counter 0..15, flag=1, drain_done one cycle after addr 0x010F.
REQ-029 ext_valid held while drain_req at base 0x3FF8 -> ext_ready 0 for 17 cycles, addresses wrap 0x3FF8..0x3FFF,0x0000..0x0007; ext word written after done; stall_cnt = 17 with macro, 0 without.
REQ-030 Second drain_req (base 0x0200) at counter 5 -> 32 contiguous write cycles, second burst 0x0200..0x020F, two drain_done pulses.
REQ-031 arst_n_in low at counter 7 -> csb=1, counter 0, no drain_done; after release a fresh drain_req restarts at counter 0.
